// File: rtl/sap_1_controller_sequencer.sv
// sap_1_controller_sequencer: SAP-1 ring-counter sequencer and control-word decoder.
// Ports: Clk, Clr (sync active-high, sampled on falling edge), opcode[3:0] (IR upper nibble),
//   T[5:0] (one-hot ring, bit0=T1), control bus Cp, Ep, LMbar, CEbar, LIbar, EIbar,
//   LAbar, EA, Su, EU, LBbar, LObar, and HLTbar when SAP_1_HALT_EN is defined.
// Optional feature macro: SAP_1_HALT_EN (HLT freezes the ring at T4 and asserts HLTbar).
module sap_1_controller_sequencer (
  input  logic       Clk,
  input  logic       Clr,
  input  logic [3:0] opcode,
  output logic [5:0] T,
  output logic       Cp,
  output logic       Ep,
  output logic       LMbar,
  output logic       CEbar,
  output logic       LIbar,
  output logic       EIbar,
  output logic       LAbar,
  output logic       EA,
  output logic       Su,
  output logic       EU,
  output logic       LBbar,
`ifdef SAP_1_HALT_EN
  output logic       LObar,
  output logic       HLTbar
`else
  output logic       LObar
`endif
);
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } state_t;
  state_t t_q, t_d;
  logic lda, add, sub, out, arith, mem_op, hlt;
  assign lda    = opcode == 4'b0000;
  assign add    = opcode == 4'b0001;
  assign sub    = opcode == 4'b0010;
  assign out    = opcode == 4'b1110;
  assign arith  = add || sub;
  assign mem_op = lda || arith;
`ifdef SAP_1_HALT_EN
  assign hlt = opcode == 4'b1111;
`else
  assign hlt = 1'b0;
`endif
  // Advancing on the falling edge keeps the control word stable across each rising edge.
  always_ff @(negedge Clk)
    t_q <= Clr ? T1 : t_d;
  always_comb begin
    t_d = T1;
    case (t_q)
      T1:      t_d = T2;
      T2:      t_d = T3;
      T3:      t_d = T4;
      T4:      t_d = hlt ? T4 : T5;
      T5:      t_d = T6;
      default: t_d = T1;
    endcase
  end
  assign T     = t_q;
  assign Ep    = t_q[0];
  assign Cp    = t_q[1];
  assign LMbar = !(t_q[0] || (t_q[3] && mem_op));
  assign CEbar = !(t_q[2] || (t_q[4] && mem_op));
  assign LIbar = !t_q[2];
  assign EIbar = !(t_q[3] && mem_op);
  assign LAbar = !((t_q[4] && lda) || (t_q[5] && arith));
  assign EA    = t_q[3] && out;
  assign Su    = t_q[5] && sub;
  assign EU    = t_q[5] && arith;
  assign LBbar = !(t_q[4] && arith);
  assign LObar = !(t_q[3] && out);
`ifdef SAP_1_HALT_EN
  assign HLTbar = !(t_q[3] && hlt);
`endif
endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// tb_sap_1_controller_sequencer: directed-vector bench for the SAP-1 controller-sequencer.
module tb_sap_1_controller_sequencer;
  logic       Clk = 1'b0;
  logic       Clr = 1'b1;
  logic [3:0] opcode = 4'b0000;
  logic [5:0] T;
  logic       Cp, Ep, LMbar, CEbar, LIbar, EIbar, LAbar, EA, Su, EU, LBbar, LObar;
`ifdef SAP_1_HALT_EN
  logic       HLTbar;
`endif
  int checks = 0;
  int errors = 0;
  logic abort_win = 1'b0;
  logic pulse_seen = 1'b0;
  sap_1_controller_sequencer dut (
    .Clk(Clk), .Clr(Clr), .opcode(opcode), .T(T),
    .Cp(Cp), .Ep(Ep), .LMbar(LMbar), .CEbar(CEbar), .LIbar(LIbar), .EIbar(EIbar),
    .LAbar(LAbar), .EA(EA), .Su(Su), .EU(EU), .LBbar(LBbar),
`ifdef SAP_1_HALT_EN
    .LObar(LObar), .HLTbar(HLTbar)
`else
    .LObar(LObar)
`endif
  );
  always #5 Clk = ~Clk;
  // Control word order: Cp Ep LMbar CEbar LIbar EIbar LAbar EA Su EU LBbar LObar
  localparam logic [11:0] W_NOP = 12'h3E3;
  localparam logic [11:0] W_T1  = 12'h5E3;
  localparam logic [11:0] W_T2  = 12'hBE3;
  localparam logic [11:0] W_T3  = 12'h263;
  localparam logic [11:0] W_MAR = 12'h1A3;
  localparam logic [11:0] W_LDA = 12'h2C3;
  localparam logic [11:0] W_LDB = 12'h2E1;
  localparam logic [11:0] W_ADD = 12'h3C7;
  localparam logic [11:0] W_SUB = 12'h3CF;
  localparam logic [11:0] W_OUT = 12'h3F2;
  always @(posedge Clk)
    if (abort_win && (EU || !LAbar)) pulse_seen <= 1'b1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge Clk);
    #1;
  endtask
  task automatic chk_state(input string tag, input logic [5:0] t_exp, input logic [11:0] w_exp);
    chk(tag, {14'd0, T, Cp, Ep, LMbar, CEbar, LIbar, EIbar, LAbar, EA, Su, EU, LBbar, LObar},
        {14'd0, t_exp, w_exp});
  endtask
  task automatic instr(input string name, input logic [3:0] op,
                       input logic [11:0] w4, input logic [11:0] w5, input logic [11:0] w6);
    opcode = op;
    chk_state({name, " T1"}, 6'b000001, W_T1);
    step();
    chk_state({name, " T2"}, 6'b000010, W_T2);
    step();
    chk_state({name, " T3"}, 6'b000100, W_T3);
    step();
    chk_state({name, " T4"}, 6'b001000, w4);
    step();
    chk_state({name, " T5"}, 6'b010000, w5);
    step();
    chk_state({name, " T6"}, 6'b100000, w6);
    step();
  endtask
  initial begin
    Clr = 1'b1;
    step();
    step();
    chk_state("reset T1", 6'b000001, W_T1);
`ifdef SAP_1_HALT_EN
    chk("reset HLTbar", {31'd0, HLTbar}, 32'd1);
`endif
    Clr = 1'b0;
    instr("LDA", 4'b0000, W_MAR, W_LDA, W_NOP);
    instr("ADD", 4'b0001, W_MAR, W_LDB, W_ADD);
    instr("SUB", 4'b0010, W_MAR, W_LDB, W_SUB);
    instr("OUT", 4'b1110, W_OUT, W_NOP, W_NOP);
    instr("UND", 4'b0111, W_NOP, W_NOP, W_NOP);
    chk_state("wrap T1", 6'b000001, W_T1);
    opcode = 4'b0001;
    step();
    step();
    step();
    step();
    chk_state("abort T5", 6'b010000, W_LDB);
    abort_win = 1'b1;
    Clr = 1'b1;
    step();
    chk_state("abort T1", 6'b000001, W_T1);
    Clr = 1'b0;
    step();
    step();
    chk_state("abort T3", 6'b000100, W_T3);
    opcode = 4'b0111;
    step();
    step();
    step();
    abort_win = 1'b0;
    chk("abort no pulse", {31'd0, pulse_seen}, 32'd0);
    step();
    chk_state("post abort T1", 6'b000001, W_T1);
    opcode = 4'b1111;
    step();
    step();
    step();
    chk_state("HLT T4", 6'b001000, W_NOP);
`ifdef SAP_1_HALT_EN
    chk("HLT HLTbar", {31'd0, HLTbar}, 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk_state("HLT frozen", 6'b001000, W_NOP);
    chk("HLT frozen HLTbar", {31'd0, HLTbar}, 32'd0);
    Clr = 1'b1;
    step();
    chk_state("HLT clr T1", 6'b000001, W_T1);
    chk("HLT clr HLTbar", {31'd0, HLTbar}, 32'd1);
    Clr = 1'b0;
`else
    step();
    chk_state("HLT nop T5", 6'b010000, W_NOP);
    step();
    chk_state("HLT nop T6", 6'b100000, W_NOP);
    step();
    chk_state("HLT nop T1", 6'b000001, W_T1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
